conv_job_ctrl: RTL and testbench
================================

# conv_job_ctrl

Job sequencer for the 3x3 convolution accelerator, `CONV_ACC`. It accepts one convolution job at a time from the host side and latches the job's channel configuration and buffer base addresses. It then pulses `start_conv` and generates the IFM and weight byte addresses in step with the accelerator's `ifm_read`/`wgt_read` strobes. It counts OFM beats, checks every stream against its expected length, and reports completion with an error status.

## Interface
- `TI`, default 16: output tile width; tile factor is 64/TI.
- `ROW_GROUPS`, default 13: row groups per tile column.
- `ADDR_W`, default 20: byte-address width of the IFM and weight memories.
- `WDOG_CYCLES`, default 4096: idle-cycle limit; used only with `CONV_JOB_CTRL_WDOG_EN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  host offers a job.
- `job_ready`  out  1  high only in IDLE.
- `job_ci`, `job_co`  in  2  channel config; channels = (cfg+1)*8.
- `job_ifm_base`, `job_wgt_base`  in  ADDR_W  byte base addresses.
- `job_done`  out  1  one-cycle completion pulse.
- `job_err`  out  4  sticky status {timeout, wgt_len_mismatch, ifm_len_mismatch, overrun/spurious}; cleared on job accept.
- `ofm_beats`  out  16  OFM values counted for the current or last job.
- `start_conv`  out  1  one-cycle start pulse to the accelerator.
- `cfg_ci`, `cfg_co`  out  2  latched config, held for the whole job.
- `ifm_read`, `wgt_read`  in  1  accelerator read strobes.
- `ifm_addr`, `wgt_addr`  out  ADDR_W  base + running byte count; combinational from registers.
- `ofm_port0_v`, `ofm_port1_v`  in  1  accelerator OFM valids.
- `end_conv`  in  1  accelerator completion.

## Operation
- FSM states: IDLE, LAUNCH, RUN, DONE.
  - IDLE → LAUNCH on `job_valid && job_ready`. The accept cycle latches ci, co and both bases, clears the counters and `job_err`, and zeroes `ofm_beats`.
  - LAUNCH: `start_conv`=1 for exactly one cycle, then RUN.
  - RUN → DONE on `end_conv`. With the watchdog compiled in, RUN → DONE also on timeout.
  - DONE: `job_done`=1 for one cycle, then IDLE.
- Expected lengths in bytes:
  - ifm_len = (ci+1)·8·(TI+2)·(64/TI)·ROW_GROUPS·8.
  - wgt_len = 9·(ci+1)·8·(co+1)·8·ROW_GROUPS·(64/TI).
  - With defaults and ci=co=0: 59904 and 29952.
- Address counters:
  - In RUN, each `ifm_read` cycle adds 6 to ifm_cnt; each `wgt_read` cycle adds 3 to wgt_cnt.
  - Both strobes in the same cycle: both counters advance.
- Overrun: a strobe arriving when its count is already ≥ its length sets `job_err[0]`. That counter does not advance and its address holds.
- Spurious activity: `ifm_read`, `wgt_read` or `end_conv` while in IDLE, LAUNCH or DONE sets `job_err[0]` and is otherwise ignored. The exception is IDLE after reset, before the first job, where such activity is ignored without setting the bit.
- `ofm_beats` adds `ofm_port0_v + ofm_port1_v` every cycle in RUN and saturates at 0xFFFF.
- On the cycle `end_conv` is seen in RUN, lengths are checked: ifm_cnt≠ifm_len sets bit 1; wgt_cnt≠wgt_len sets bit 2.
- `cfg_ci`/`cfg_co` hold the latched values outside a job as well, until the next accept.

## Timing
- Job accepted at cycle T → `start_conv` high at T+1 → RUN from T+2.
- `ifm_addr`/`wgt_addr` are valid in the same cycle as the strobe (zero latency), so the memory read is asynchronous and the accelerator samples data that cycle.
- `end_conv` at cycle E → `job_done` at E+1 → `job_ready` at E+2.
- `job_err` and `ofm_beats` are stable from the `job_done` cycle until the next accept.
- Reset values: `job_ready`=1 (IDLE); all other outputs 0, including `start_conv`, `job_done`, `job_err`, `ofm_beats`, `cfg_*` and both addresses.
- Reset during any state returns to IDLE the next cycle with no `job_done`.

## Configuration
- `CONV_JOB_CTRL_WDOG_EN` defined:
  - A RUN-only idle counter clears on any strobe or OFM valid.
  - When it reaches `WDOG_CYCLES`, `job_err[3]` is set and the FSM goes to DONE.
- Undefined: no counter is built, `job_err[3]` is tied to 0 and RUN exits only on `end_conv`.

## Structure
- Shared package `conv_pkg`:
  - FSM state enum.
  - Bytes-per-beat constants, IFM 6 and WGT 3.
  - Error bit indices.
  - Length functions `ifm_len(ci)` and `wgt_len(ci,co)`.
- One sub-module, `conv_addr_gen`. It is instantiated twice (IFM, WGT) and parameterised by step. Inputs: base, len, strobe, clear. Outputs: addr, overrun, count_match.

## Test plan
- ci=co=0, bases 0x100/0x8000. Accelerator model issues 9984 `ifm_read` and 9984 `wgt_read`, then `end_conv` → final `ifm_addr`=0x100+59904, `wgt_addr`=0x8000+29952, `job_done` one cycle after `end_conv`, `job_err`=0.
- ci=1, co=2: `end_conv` after only 100 ifm reads → `job_err`=4'b0110.
- Extra `ifm_read` after 59904 bytes have been consumed → `job_err[0]`=1, `ifm_addr` holds.
- `job_valid` held high during RUN → `job_ready`=0 and no second accept. New accept occurs at `job_done`+1 with `job_err` cleared.
- `rst` asserted mid-RUN → next cycle IDLE, `job_ready`=1, `start_conv`=0, addresses 0, no `job_done`.
- With `CONV_JOB_CTRL_WDOG_EN` and `WDOG_CYCLES`=16: no activity for 16 RUN cycles → `job_err[3]`=1 and `job_done` pulses. Without the macro the bench stays in RUN.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution job sequencer: FSM state encoding,
// bytes consumed per accelerator read strobe, job_err bit positions and the
// expected IFM/weight stream lengths for a job.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } conv_state_e;

    // Bytes the accelerator consumes on each read strobe
    localparam int unsigned IFM_BYTES_PER_BEAT = 6;
    localparam int unsigned WGT_BYTES_PER_BEAT = 3;

    // job_err bit positions
    localparam int ERR_OVR     = 0;   // overrun or spurious strobe
    localparam int ERR_IFM_LEN = 1;
    localparam int ERR_WGT_LEN = 2;
    localparam int ERR_TIMEOUT = 3;

    // IFM bytes for one job: channels * padded tile width * tiles * row groups * 8 rows
    function automatic int unsigned ifm_len(input logic [1:0] ci,
                                            input int unsigned ti = 16,
                                            input int unsigned rg = 13);
        return (32'(ci) + 1) * 8 * (ti + 2) * (64 / ti) * rg * 8;
    endfunction

    // Weight bytes for one job: 3x3 kernel * in channels * out channels * passes
    function automatic int unsigned wgt_len(input logic [1:0] ci,
                                            input logic [1:0] co,
                                            input int unsigned ti = 16,
                                            input int unsigned rg = 13);
        return 9 * (32'(ci) + 1) * 8 * (32'(co) + 1) * 8 * rg * (64 / ti);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Byte-address generator for one accelerator read stream. Keeps a running
// byte count that advances by STEP per strobe, refuses to advance past the
// expected length (flagging overrun instead) and reports an exact length match.
module conv_addr_gen #(
    parameter int ADDR_W = 20,
    parameter int STEP   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              overrun,
    output logic              count_match
);

    logic [ADDR_W-1:0] cnt_reg;

    // Address is valid in the strobe cycle itself so the memory can be read asynchronously
    assign addr        = base + cnt_reg;
    assign overrun     = strobe && (cnt_reg >= len);
    assign count_match = (cnt_reg == len);

    // Running byte count; an overrunning strobe leaves the count (and address) unchanged
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (strobe && !overrun) begin
            cnt_reg <= cnt_reg + ADDR_W'(STEP);
        end
    end

endmodule

// File: rtl/conv_job_ctrl.sv
// Job sequencer for the 3x3 convolution accelerator: accepts a job, pulses
// start_conv, generates IFM/weight addresses, counts OFM beats and reports
// completion with a sticky error status.
// Optional watchdog: define CONV_JOB_CTRL_WDOG_EN to build the RUN idle timeout.
module conv_job_ctrl
    import conv_pkg::*;
#(
    parameter int TI          = 16,
    parameter int ROW_GROUPS  = 13,
    parameter int ADDR_W      = 20,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1:0]        job_ci,
    input  logic [1:0]        job_co,
    input  logic [ADDR_W-1:0] job_ifm_base,
    input  logic [ADDR_W-1:0] job_wgt_base,
    output logic              job_done,
    output logic [3:0]        job_err,
    output logic [15:0]       ofm_beats,
    output logic              start_conv,
    output logic [1:0]        cfg_ci,
    output logic [1:0]        cfg_co,
    input  logic              ifm_read,
    input  logic              wgt_read,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic              ofm_port0_v,
    input  logic              ofm_port1_v,
    input  logic              end_conv
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [1:0] S_RUN    = ST_RUN;
    localparam logic [1:0] S_DONE   = ST_DONE;

    logic [1:0]        state_reg, state_next;
    logic [1:0]        cfg_ci_reg, cfg_co_reg;
    logic [ADDR_W-1:0] ifm_base_reg, wgt_base_reg;
    logic [3:0]        err_reg, err_next;
    logic [15:0]       beats_reg;
    logic [16:0]       beats_sum;
    logic              seen_job_reg;

    logic              accept, in_run, ifm_stb, wgt_stb, spurious, timeout;
    logic [ADDR_W-1:0] ifm_len_w, wgt_len_w;
    logic              ifm_ovr, wgt_ovr, ifm_match, wgt_match;

    assign job_ready  = (state_reg == S_IDLE);
    assign start_conv = (state_reg == S_LAUNCH);
    assign job_done   = (state_reg == S_DONE);
    assign in_run     = (state_reg == S_RUN);
    assign accept     = job_valid && job_ready;
    assign job_err    = err_reg;
    assign ofm_beats  = beats_reg;
    assign cfg_ci     = cfg_ci_reg;
    assign cfg_co     = cfg_co_reg;

    // Strobes only count while running; elsewhere they are spurious, except
    // before the very first job when the accelerator may still be settling.
    assign ifm_stb  = ifm_read && in_run;
    assign wgt_stb  = wgt_read && in_run;
    assign spurious = (ifm_read || wgt_read || end_conv) && !in_run &&
                      !((state_reg == S_IDLE) && !seen_job_reg);

    assign ifm_len_w = ADDR_W'(ifm_len(cfg_ci_reg, TI, ROW_GROUPS));
    assign wgt_len_w = ADDR_W'(wgt_len(cfg_ci_reg, cfg_co_reg, TI, ROW_GROUPS));

    conv_addr_gen #(.ADDR_W(ADDR_W), .STEP(IFM_BYTES_PER_BEAT)) u_ifm_gen (
        .clk(clk), .rst(rst), .clear(accept), .strobe(ifm_stb),
        .base(ifm_base_reg), .len(ifm_len_w),
        .addr(ifm_addr), .overrun(ifm_ovr), .count_match(ifm_match)
    );

    conv_addr_gen #(.ADDR_W(ADDR_W), .STEP(WGT_BYTES_PER_BEAT)) u_wgt_gen (
        .clk(clk), .rst(rst), .clear(accept), .strobe(wgt_stb),
        .base(wgt_base_reg), .len(wgt_len_w),
        .addr(wgt_addr), .overrun(wgt_ovr), .count_match(wgt_match)
    );

`ifdef CONV_JOB_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] idle_cnt_reg;
    logic              activity;

    assign activity = ifm_read || wgt_read || ofm_port0_v || ofm_port1_v;
    assign timeout  = in_run && !activity && (idle_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));

    // Idle-cycle counter, only meaningful in RUN; any accelerator activity restarts it
    always_ff @(posedge clk) begin
        if (rst || !in_run || activity) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    // No watchdog: a negative limit is impossible, so timeout never fires
    assign timeout = (WDOG_CYCLES < 0);
`endif

    // Next-state decode for the job FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_RUN;
            S_RUN:    if (end_conv || timeout) state_next = S_DONE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Sticky error status: cleared on accept, otherwise bits only ever set
    always_comb begin
        err_next = err_reg;
        if (accept) begin
            err_next = '0;
        end else begin
            if (spurious || ifm_ovr || wgt_ovr) err_next[ERR_OVR] = 1'b1;
            if (in_run && end_conv && !ifm_match) err_next[ERR_IFM_LEN] = 1'b1;
            if (in_run && end_conv && !wgt_match) err_next[ERR_WGT_LEN] = 1'b1;
            if (timeout) err_next[ERR_TIMEOUT] = 1'b1;
        end
    end

    assign beats_sum = {1'b0, beats_reg} + 17'(ofm_port0_v) + 17'(ofm_port1_v);

    // State, job configuration latch, error status and saturating OFM beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cfg_ci_reg   <= '0;
            cfg_co_reg   <= '0;
            ifm_base_reg <= '0;
            wgt_base_reg <= '0;
            err_reg      <= '0;
            beats_reg    <= '0;
            seen_job_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (accept) begin
                cfg_ci_reg   <= job_ci;
                cfg_co_reg   <= job_co;
                ifm_base_reg <= job_ifm_base;
                wgt_base_reg <= job_wgt_base;
                beats_reg    <= '0;
                seen_job_reg <= 1'b1;
            end else if (in_run) begin
                beats_reg <= beats_sum[16] ? 16'hFFFF : beats_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Self-checking bench for conv_job_ctrl: a behavioural accelerator drives
// read strobes and OFM valids, a small model predicts addresses and status,
// and per-job expectations are queued and compared at job_done.
// Define CONV_JOB_CTRL_WDOG_EN to exercise the watchdog build.
module tb_conv_job_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [1:0]        job_ci, job_co;
    logic [ADDR_W-1:0] job_ifm_base, job_wgt_base;
    logic              job_done;
    logic [3:0]        job_err;
    logic [15:0]       ofm_beats;
    logic              start_conv;
    logic [1:0]        cfg_ci, cfg_co;
    logic              ifm_read, wgt_read;
    logic [ADDR_W-1:0] ifm_addr, wgt_addr;
    logic              ofm_port0_v, ofm_port1_v;
    logic              end_conv;

    always #5 clk = ~clk;

    conv_job_ctrl #(
        .TI(16), .ROW_GROUPS(13), .ADDR_W(ADDR_W), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_ci(job_ci), .job_co(job_co),
        .job_ifm_base(job_ifm_base), .job_wgt_base(job_wgt_base),
        .job_done(job_done), .job_err(job_err), .ofm_beats(ofm_beats),
        .start_conv(start_conv), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
        .ifm_read(ifm_read), .wgt_read(wgt_read),
        .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
        .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v),
        .end_conv(end_conv)
    );

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    typedef struct {
        logic [3:0]        err;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] wa;
        logic [15:0]       beats;
    } exp_t;
    exp_t sb_q[$];

    // Accelerator/controller model
    int unsigned       m_ilen, m_wlen, m_icnt, m_wcnt, m_beats;
    logic [3:0]        m_err;
    logic [ADDR_W-1:0] m_ib, m_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input logic [1:0] ci, input logic [1:0] co,
                               input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] wb);
        // TI=16 -> padded width 18, 4 tiles; 13 row groups
        m_ilen  = (32'(ci) + 1) * 8 * 18 * 4 * 13 * 8;
        m_wlen  = 9 * (32'(ci) + 1) * 8 * (32'(co) + 1) * 8 * 13 * 4;
        m_icnt  = 0;
        m_wcnt  = 0;
        m_beats = 0;
        m_err   = 4'b0000;
        m_ib    = ib;
        m_wb    = wb;
    endtask

    task automatic accept_job(input logic [1:0] ci, input logic [1:0] co,
                              input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] wb,
                              input bit hold);
        @(negedge clk);
        job_valid    = 1'b1;
        job_ci       = ci;
        job_co       = co;
        job_ifm_base = ib;
        job_wgt_base = wb;
        model_reset(ci, co, ib, wb);
        @(negedge clk);
        check("start_conv", 32'(start_conv), 32'd1);
        check("launch_ready", 32'(job_ready), 32'd0);
        check("cfg_ci", 32'(cfg_ci), 32'(ci));
        check("cfg_co", 32'(cfg_co), 32'(co));
        check("err_clear", 32'(job_err), 32'd0);
        check("beats_clear", 32'(ofm_beats), 32'd0);
        if (!hold) job_valid = 1'b0;
        @(negedge clk);
        check("start_once", 32'(start_conv), 32'd0);
    endtask

    // Accelerator model: issue reads and OFM valids, checking zero-latency addresses
    task automatic stream(input int n_ifm, input int n_wgt);
        int n;
        logic p0, p1;
        n = (n_ifm > n_wgt) ? n_ifm : n_wgt;
        for (int i = 0; i < n; i++) begin
            if (i < n_ifm) check("ifm_addr", 32'(ifm_addr), 32'(m_ib) + m_icnt);
            if (i < n_wgt) check("wgt_addr", 32'(wgt_addr), 32'(m_wb) + m_wcnt);
            p0 = (i % 3 == 0);
            p1 = (i % 7 == 0);
            ifm_read    = (i < n_ifm);
            wgt_read    = (i < n_wgt);
            ofm_port0_v = p0;
            ofm_port1_v = p1;
            if (i < n_ifm) begin
                if (m_icnt >= m_ilen) m_err[0] = 1'b1;
                else m_icnt += 6;
            end
            if (i < n_wgt) begin
                if (m_wcnt >= m_wlen) m_err[0] = 1'b1;
                else m_wcnt += 3;
            end
            m_beats += 32'(p0) + 32'(p1);
            if (m_beats > 32'hFFFF) m_beats = 32'hFFFF;
            @(negedge clk);
        end
        ifm_read    = 1'b0;
        wgt_read    = 1'b0;
        ofm_port0_v = 1'b0;
        ofm_port1_v = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int exp_lat);
        exp_t e;
        int k;
        k = 0;
        while (!job_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("job_done_seen", 32'(job_done), 32'd1);
        if (exp_lat >= 0) check("done_latency", 32'(k), 32'(exp_lat));
        if (job_done && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("job_err", 32'(job_err), 32'(e.err));
            check("final_ifm_addr", 32'(ifm_addr), 32'(e.ia));
            check("final_wgt_addr", 32'(wgt_addr), 32'(e.wa));
            check("ofm_beats", 32'(ofm_beats), 32'(e.beats));
            $display("job done: err=%b ifm_addr=0x%0h wgt_addr=0x%0h beats=%0d",
                     job_err, ifm_addr, wgt_addr, ofm_beats);
        end
        @(negedge clk);
        check("done_pulse", 32'(job_done), 32'd0);
        check("ready_after", 32'(job_ready), 32'd1);
    endtask

    task automatic finish_job();
        exp_t e;
        check("run_ready", 32'(job_ready), 32'd0);
        end_conv = 1'b1;
        if (m_icnt != m_ilen) m_err[1] = 1'b1;
        if (m_wcnt != m_wlen) m_err[2] = 1'b1;
        e.err   = m_err;
        e.ia    = m_ib + ADDR_W'(m_icnt);
        e.wa    = m_wb + ADDR_W'(m_wcnt);
        e.beats = 16'(m_beats);
        sb_q.push_back(e);
        @(negedge clk);
        end_conv = 1'b0;
        wait_done(4, 0);
    endtask

    initial begin
        exp_t e;
        bit   done_seen;
        rst = 1'b1;
        job_valid = 1'b0; job_ci = '0; job_co = '0;
        job_ifm_base = '0; job_wgt_base = '0;
        ifm_read = 1'b0; wgt_read = 1'b0;
        ofm_port0_v = 1'b0; ofm_port1_v = 1'b0; end_conv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(job_ready), 32'd1);
        check("rst_start", 32'(start_conv), 32'd0);
        check("rst_done", 32'(job_done), 32'd0);
        check("rst_err", 32'(job_err), 32'd0);
        check("rst_beats", 32'(ofm_beats), 32'd0);
        check("rst_ifm_addr", 32'(ifm_addr), 32'd0);
        check("rst_wgt_addr", 32'(wgt_addr), 32'd0);

        // Activity before the first job is ignored silently
        ifm_read = 1'b1; wgt_read = 1'b1; end_conv = 1'b1;
        @(negedge clk);
        ifm_read = 1'b0; wgt_read = 1'b0; end_conv = 1'b0;
        @(negedge clk);
        check("prejob_spurious", 32'(job_err), 32'd0);

        // Full-length job, ci=co=0
        accept_job(2'd0, 2'd0, 20'h00100, 20'h08000, 1'b0);
        stream(9984, 9984);
        finish_job();
        check("job1_ifm_end", 32'(ifm_addr), 32'h100 + 32'd59904);
        check("job1_wgt_end", 32'(wgt_addr), 32'h8000 + 32'd29952);

        // Spurious strobe in IDLE after a job sets bit 0
        wgt_read = 1'b1;
        @(negedge clk);
        wgt_read = 1'b0;
        @(negedge clk);
        check("idle_spurious", 32'(job_err), 32'd1);

        // Short job: both lengths mismatch
        accept_job(2'd1, 2'd2, 20'h02000, 20'h40000, 1'b0);
        stream(100, 0);
        finish_job();

        // One IFM read past the end: overrun, address holds
        accept_job(2'd0, 2'd0, 20'h00100, 20'h08000, 1'b0);
        stream(9985, 9984);
        finish_job();

        // job_valid held through the job: no second accept until IDLE
        accept_job(2'd1, 2'd2, 20'h01000, 20'h02000, 1'b1);
        stream(10, 10);
        finish_job();
        @(negedge clk);
        check("reaccept_start", 32'(start_conv), 32'd1);
        check("reaccept_err_clr", 32'(job_err), 32'd0);
        job_valid = 1'b0;
        model_reset(2'd1, 2'd2, 20'h01000, 20'h02000);
        @(negedge clk);
        stream(5, 5);

        // Reset in the middle of RUN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(job_ready), 32'd1);
        check("midrst_start", 32'(start_conv), 32'd0);
        check("midrst_done", 32'(job_done), 32'd0);
        check("midrst_ifm_addr", 32'(ifm_addr), 32'd0);
        check("midrst_wgt_addr", 32'(wgt_addr), 32'd0);
        check("midrst_cfg_ci", 32'(cfg_ci), 32'd0);
        @(negedge clk);
        check("midrst_no_done", 32'(job_done), 32'd0);

        // Idle accelerator during RUN
        accept_job(2'd0, 2'd0, 20'h00300, 20'h00500, 1'b0);
`ifdef CONV_JOB_CTRL_WDOG_EN
        e.err = 4'b1000; e.ia = 20'h00300; e.wa = 20'h00500; e.beats = 16'd0;
        sb_q.push_back(e);
        wait_done(40, -1);
`else
        done_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (job_done) done_seen = 1'b1;
        end
        check("no_wdog_done", 32'(done_seen), 32'd0);
        finish_job();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
